// File: rtl/fetch_unit_pipeline.sv
// Instruction fetch stage: issues in-order word requests to instruction memory and
// buffers up to two {pc, instr} pairs for Decode, with redirect, flush and halt support.
module fetch_unit_pipeline #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_load,
   input  logic [15:0] pc_offset,
   input  logic [15:0] ex_pc,
   input  logic        flush_pipeline,
   input  logic        cpu_halt,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [15:0] imem_rdata,
   output logic        if_valid,
   output logic [15:0] if_instr,
   output logic [15:0] if_pc,
   input  logic        id_ready
);

   logic [15:0] fetch_pc_reg;

   logic [15:0] fifo_pc_reg    [2];
   logic [15:0] fifo_instr_reg [2];
   logic        fifo_rd_reg;
   logic        fifo_wr_reg;
   logic [1:0]  fifo_cnt_reg;

   logic [15:0] infl_pc_reg [2];
   logic        infl_rd_reg;
   logic        infl_wr_reg;
   logic [1:0]  infl_cnt_reg;

   logic [1:0]  drop_cnt_reg;

   logic        pop;
   logic        push;
   logic        grant;
   logic        rsp_drop;
   logic [2:0]  credit_used;
   logic [2:0]  pending_total;
   logic [15:0] redirect_pc;

   assign pop = (fifo_cnt_reg != 2'd0) && id_ready && !rst;

   // A slot freed by this cycle's pop is reusable now, which is what sustains
   // one instruction per cycle at single-cycle memory latency.
   assign credit_used = {1'b0, infl_cnt_reg} + {1'b0, fifo_cnt_reg} - {2'b00, pop};

   assign imem_req = !rst && (credit_used < 3'd2) && !cpu_halt && !pc_load
                     && !flush_pipeline && (drop_cnt_reg == 2'd0);
   assign grant    = imem_req && imem_gnt;

   assign rsp_drop = imem_rvalid && (drop_cnt_reg != 2'd0);
   assign push     = imem_rvalid && (drop_cnt_reg == 2'd0) && (infl_cnt_reg != 2'd0);

   assign pending_total = {1'b0, drop_cnt_reg} + {1'b0, infl_cnt_reg};
   assign redirect_pc   = ex_pc + pc_offset;

   assign imem_addr = rst ? RESET_PC : fetch_pc_reg;
   assign if_valid  = !rst && (fifo_cnt_reg != 2'd0);
   assign if_instr  = rst ? 16'h0000 : fifo_instr_reg[fifo_rd_reg];
   assign if_pc     = rst ? 16'h0000 : fifo_pc_reg[fifo_rd_reg];

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_reg <= RESET_PC;
         fifo_rd_reg  <= 1'b0;
         fifo_wr_reg  <= 1'b0;
         fifo_cnt_reg <= 2'd0;
         infl_rd_reg  <= 1'b0;
         infl_wr_reg  <= 1'b0;
         infl_cnt_reg <= 2'd0;
         drop_cnt_reg <= 2'd0;
      end else if (flush_pipeline) begin
         if (pc_load) begin
            fetch_pc_reg <= redirect_pc;
         end
         fifo_rd_reg  <= 1'b0;
         fifo_wr_reg  <= 1'b0;
         fifo_cnt_reg <= 2'd0;
         infl_rd_reg  <= 1'b0;
         infl_wr_reg  <= 1'b0;
         infl_cnt_reg <= 2'd0;
         // Responses return in order, so one arriving now retires the oldest pending request.
         drop_cnt_reg <= 2'(pending_total - {2'b00, imem_rvalid && (pending_total != 3'd0)});
      end else begin
         if (pc_load) begin
            fetch_pc_reg <= redirect_pc;
         end else if (grant) begin
            fetch_pc_reg <= fetch_pc_reg + 16'd1;
         end
         if (push) begin
            fifo_wr_reg <= ~fifo_wr_reg;
            infl_rd_reg <= ~infl_rd_reg;
         end
         if (pop) begin
            fifo_rd_reg <= ~fifo_rd_reg;
         end
         if (grant) begin
            infl_wr_reg <= ~infl_wr_reg;
         end
         fifo_cnt_reg <= fifo_cnt_reg + {1'b0, push} - {1'b0, pop};
         infl_cnt_reg <= infl_cnt_reg + {1'b0, grant} - {1'b0, push};
         if (rsp_drop) begin
            drop_cnt_reg <= drop_cnt_reg - 2'd1;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (rst) begin
               fifo_pc_reg[gi]    <= 16'h0000;
               fifo_instr_reg[gi] <= 16'h0000;
            end else if (!flush_pipeline && push && (fifo_wr_reg == 1'(gi))) begin
               fifo_pc_reg[gi]    <= infl_pc_reg[infl_rd_reg];
               fifo_instr_reg[gi] <= imem_rdata;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               infl_pc_reg[gi] <= 16'h0000;
            end else if (grant && (infl_wr_reg == 1'(gi))) begin
               infl_pc_reg[gi] <= fetch_pc_reg;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_fetch_unit_pipeline.sv
// Directed bench for fetch_unit_pipeline: in-order memory model with selectable latency,
// delivery monitor tracking the expected PC stream, one line per comparison.
module tb_fetch_unit_pipeline;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_load;
   logic [15:0] pc_offset;
   logic [15:0] ex_pc;
   logic        flush_pipeline;
   logic        cpu_halt;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [15:0] imem_rdata;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [15:0] if_pc;
   logic        id_ready;

   int          checks = 0;
   int          errors = 0;
   int          delivered = 0;
   int          lat = 1;
   logic        inject = 1'b0;
   logic [15:0] exp_pc;
   logic        jump_armed = 1'b0;
   logic [15:0] jump_after;
   logic [15:0] jump_to;
   logic [15:0] held_addr;

   logic [3:0]  pipe_v;
   logic [15:0] pipe_a [4];

   fetch_unit_pipeline dut (
      .clk            (clk),
      .rst            (rst),
      .pc_load        (pc_load),
      .pc_offset      (pc_offset),
      .ex_pc          (ex_pc),
      .flush_pipeline (flush_pipeline),
      .cpu_halt       (cpu_halt),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .id_ready       (id_ready)
   );

   always #5 clk = ~clk;

   // Memory: fixed latency shift pipe, reset together with the fetch unit; word = addr + 0x1000.
   always @(posedge clk) begin
      if (rst) begin
         pipe_v <= 4'b0000;
      end else begin
         pipe_v <= {pipe_v[2:0], imem_req && imem_gnt};
      end
      pipe_a[0] <= imem_addr;
      pipe_a[1] <= pipe_a[0];
      pipe_a[2] <= pipe_a[1];
      pipe_a[3] <= pipe_a[2];
   end

   assign imem_rvalid = pipe_v[lat-1] | inject;
   assign imem_rdata  = pipe_a[lat-1] + 16'h1000;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end else begin
         $display("chk  %s got %h", tag, got);
      end
   endtask

   task automatic mon();
      if (if_valid && id_ready) begin
         check("if_pc", {16'h0, if_pc}, {16'h0, exp_pc});
         check("if_instr", {16'h0, if_instr}, {16'h0, 16'(exp_pc + 16'h1000)});
         if (jump_armed && exp_pc == jump_after) begin
            exp_pc     = jump_to;
            jump_armed = 1'b0;
         end else begin
            exp_pc = exp_pc + 16'd1;
         end
         delivered++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         tick();
         #1;
         mon();
      end
   endtask

   initial begin
      rst = 1'b1; pc_load = 1'b0; pc_offset = 16'h0; ex_pc = 16'h0;
      flush_pipeline = 1'b0; cpu_halt = 1'b0; imem_gnt = 1'b1; id_ready = 1'b1;
      exp_pc = 16'h0000;
      repeat (2) @(posedge clk);
      #2;
      check("rst_req", {31'h0, imem_req}, 32'h0);
      check("rst_addr", {16'h0, imem_addr}, 32'h0);
      check("rst_valid", {31'h0, if_valid}, 32'h0);
      check("rst_instr", {16'h0, if_instr}, 32'h0);
      check("rst_pc", {16'h0, if_pc}, 32'h0);

      // Startup and streaming at one instruction per cycle
      tick(); rst = 1'b0; #1;
      check("c0_req", {31'h0, imem_req}, 32'h1);
      check("c0_addr", {16'h0, imem_addr}, 32'h0);
      mon();
      tick(); #1;
      check("c1_addr", {16'h0, imem_addr}, 32'h1);
      check("c1_valid", {31'h0, if_valid}, 32'h0);
      mon();
      tick(); #1;
      check("c2_valid", {31'h0, if_valid}, 32'h1);
      mon();
      for (int k = 3; k < 10; k++) begin
         tick(); #1;
         check("run_valid", {31'h0, if_valid}, 32'h1);
         check("run_addr", {16'h0, imem_addr}, 32'(k));
         mon();
      end

      // Decode stall for 5 cycles
      tick(); id_ready = 1'b0; #1; mon();
      repeat (4) begin
         tick(); #1;
         check("stall_req", {31'h0, imem_req}, 32'h0);
         check("stall_head", {16'h0, if_pc}, {16'h0, exp_pc});
      end
      tick(); id_ready = 1'b1; #1; mon();
      run(6);

      // Redirect without flush to 0xFFFF while the FIFO is full
      tick(); id_ready = 1'b0; #1;
      run(2);
      tick(); pc_load = 1'b1; ex_pc = 16'hFFF0; pc_offset = 16'h000F; #1;
      check("load_req", {31'h0, imem_req}, 32'h0);
      tick(); pc_load = 1'b0; #1;
      check("load_addr", {16'h0, imem_addr}, 32'hFFFF);
      check("load_keep", {16'h0, if_pc}, {16'h0, exp_pc});
      jump_after = exp_pc + 16'd1; jump_to = 16'hFFFF; jump_armed = 1'b1;
      tick(); id_ready = 1'b1; #1;
      check("wrap_addr0", {16'h0, imem_addr}, 32'hFFFF);
      mon();
      tick(); #1;
      check("wrap_addr1", {16'h0, imem_addr}, 32'h0000);
      check("wrap_req", {31'h0, imem_req}, 32'h1);
      mon();
      run(5);

      // Grant withheld for 3 cycles
      tick(); imem_gnt = 1'b0; #1;
      held_addr = imem_addr;
      check("nogrant_req", {31'h0, imem_req}, 32'h1);
      mon();
      repeat (2) begin
         tick(); #1;
         check("nogrant_req", {31'h0, imem_req}, 32'h1);
         check("nogrant_addr", {16'h0, imem_addr}, {16'h0, held_addr});
         mon();
      end
      tick(); imem_gnt = 1'b1; #1;
      check("nogrant_addr", {16'h0, imem_addr}, {16'h0, held_addr});
      mon();
      run(5);

      // Halt with one outstanding request
      tick(); cpu_halt = 1'b1; #1;
      held_addr = imem_addr;
      check("halt_req", {31'h0, imem_req}, 32'h0);
      mon();
      repeat (3) begin
         tick(); #1;
         check("halt_req", {31'h0, imem_req}, 32'h0);
         check("halt_addr", {16'h0, imem_addr}, {16'h0, held_addr});
         mon();
      end
      check("halt_empty", {31'h0, if_valid}, 32'h0);
      check("halt_drained", {16'h0, held_addr}, {16'h0, exp_pc});
      tick(); inject = 1'b1; #1; mon();
      tick(); inject = 1'b0; #1;
      check("spurious_rsp", {31'h0, if_valid}, 32'h0);
      tick(); cpu_halt = 1'b0; #1;
      check("resume_req", {31'h0, imem_req}, 32'h1);
      check("resume_addr", {16'h0, imem_addr}, {16'h0, held_addr});
      mon();
      run(4);
      tick(); cpu_halt = 1'b1; #1; mon();
      run(4);
      check("drain_empty", {31'h0, if_valid}, 32'h0);

      // Flush + redirect with two requests outstanding at latency 3
      lat = 3;
      tick(); cpu_halt = 1'b0; #1;
      check("fl_req0", {31'h0, imem_req}, 32'h1);
      mon();
      tick(); #1;
      check("fl_req1", {31'h0, imem_req}, 32'h1);
      mon();
      tick(); pc_load = 1'b1; flush_pipeline = 1'b1; ex_pc = 16'h0010; pc_offset = 16'hFFFC; #1;
      check("fl_req2", {31'h0, imem_req}, 32'h0);
      mon();
      tick(); pc_load = 1'b0; flush_pipeline = 1'b0; #1;
      check("drop1_req", {31'h0, imem_req}, 32'h0);
      check("drop1_addr", {16'h0, imem_addr}, 32'h000C);
      check("drop1_valid", {31'h0, if_valid}, 32'h0);
      mon();
      tick(); #1;
      check("drop2_req", {31'h0, imem_req}, 32'h0);
      check("drop2_valid", {31'h0, if_valid}, 32'h0);
      mon();
      tick(); #1;
      check("refetch_req", {31'h0, imem_req}, 32'h1);
      check("refetch_addr", {16'h0, imem_addr}, 32'h000C);
      exp_pc = 16'h000C;
      delivered = 0;
      mon();
      run(12);
      check("fl_delivered", {31'h0, delivered >= 3}, 32'h1);

      // Reset in the middle of traffic
      tick(); rst = 1'b1; #1;
      check("mid_rst_req", {31'h0, imem_req}, 32'h0);
      check("mid_rst_valid", {31'h0, if_valid}, 32'h0);
      tick(); rst = 1'b0; #1;
      check("post_rst_req", {31'h0, imem_req}, 32'h1);
      check("post_rst_addr", {16'h0, imem_addr}, 32'h0000);
      check("post_rst_valid", {31'h0, if_valid}, 32'h0);
      exp_pc = 16'h0000;
      delivered = 0;
      mon();
      run(12);
      check("rst_delivered", {31'h0, delivered >= 3}, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit_pipeline.md
FETCH_UNIT_PIPELINE -- requirements
Module: fetch_unit_pipeline

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: fetch PC loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 pc_load  input  1  redirect request from control unit (Execute stage).
REQ-005 pc_offset  input  16  signed branch/jump offset accompanying pc_load.
REQ-006 ex_pc  input  16  PC of the instruction currently in Execute.
REQ-007 flush_pipeline  input  1  discard all buffered and in-flight fetches.
REQ-008 cpu_halt  input  1  latched halt; stops new fetch requests.
REQ-009 imem_req  output  1  instruction memory request.
REQ-010 imem_addr  output  16  request word address, equals fetch PC.
REQ-011 imem_gnt  input  1  request accepted this cycle.
REQ-012 imem_rvalid  input  1  response valid; responses return in request order, latency >=1 cycle.
REQ-013 imem_rdata  input  16  response instruction word.
REQ-014 if_valid  output  1  instruction available to Decode.
REQ-015 if_instr  output  16  instruction word at buffer head.
REQ-016 if_pc  output  16  address of if_instr.
REQ-017 id_ready  input  1  Decode accepts; transfer when if_valid && id_ready.

Function
REQ-018 The block SHALL hold a 2-entry FIFO of {pc, instr}; if_valid = FIFO non-empty; if_instr/if_pc = head entry.
REQ-019 The block SHALL track outstanding requests (0-2) and SHALL assert imem_req only when outstanding + FIFO occupancy < 2, !cpu_halt, !pc_load, !flush_pipeline, and no drop pending (REQ-024).
REQ-020 On imem_req && imem_gnt the fetch PC SHALL increment by 1, wrapping 16'hFFFF -> 16'h0000; the issued address SHALL be stored in a 2-entry in-flight PC queue.
REQ-021 On imem_rvalid (not dropped) the block SHALL push {in-flight queue head pc, imem_rdata} into the FIFO the same edge; simultaneous push and pop SHALL be supported at full occupancy-1.
REQ-022 Pop SHALL occur on if_valid && id_ready; ordering strictly FIFO.
REQ-023 On pc_load the fetch PC SHALL become (ex_pc + pc_offset) mod 2^16 on the next edge; first request to the new PC no earlier than the following cycle.
REQ-024 On flush_pipeline the FIFO and in-flight PC queue SHALL clear next edge; a drop counter SHALL be set to outstanding requests not completed that cycle; subsequent imem_rvalid responses SHALL be discarded while counter > 0, decrementing per response.
REQ-025 Flush SHALL take priority over a same-cycle pop, push, or grant-accepted response; a request granted in the flush cycle SHALL count toward the drop counter (imem_req is low in that cycle, so none occurs).
REQ-026 pc_load without flush_pipeline SHALL update PC only; FIFO contents retained.
REQ-027 While cpu_halt is high, outstanding responses SHALL still be accepted and delivered; fetch PC frozen; deassertion resumes requests from frozen PC.
REQ-028 Latency: with imem latency 1 and id_ready high, sustained throughput SHALL be one instruction per cycle after a 2-cycle startup.

Reset
REQ-029 While rst is high: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=16'h0000, if_pc=16'h0000, FIFO/in-flight/drop counter cleared, fetch PC=RESET_PC.
REQ-030 rst mid-transfer SHALL discard all state; responses for pre-reset requests arriving after reset SHALL be ignored if drop counter was nonzero... no: memory is assumed reset concurrently; responses after reset with zero outstanding SHALL be ignored.
REQ-031 First imem_req SHALL assert in the first cycle after rst deasserts.

Verification
REQ-032 Reset release, gnt=1, 1-cycle latency, id_ready=1 -> if_pc sequence 0000,0001,0002... with if_valid continuous from cycle 2.
REQ-033 id_ready=0 for 5 cycles -> FIFO fills to 2, imem_req deasserts, no instruction lost or duplicated after id_ready returns.
REQ-034 pc_load+flush with ex_pc=0010, pc_offset=FFFC while 2 requests outstanding -> two stale responses dropped, next if_pc=000C.
REQ-035 Fetch PC at FFFF -> next request address 0000.
REQ-036 cpu_halt asserted with 1 outstanding -> response delivered, imem_req stays 0; deassert -> fetch resumes at frozen PC.
REQ-037 imem_gnt held low 3 cycles -> imem_req and imem_addr stable, PC unchanged.
